// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Generic two-flop synchronizer for one asynchronous input bit.
// Revision : 1.0
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : button_debounce
// Purpose  : Synchronizes and debounces a push-button pin; produces a clean
//            level, press/release pulses and a one-shot long-press pulse.
// Revision : 1.0
// ============================================================================
module button_debounce #(
    parameter int SYS_CLK     = 50000000,
    parameter int DEBOUNCE_US = 10000,
    parameter int LONG_MS     = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clk_en,
    input  logic btn_in,
    output logic pressed,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam int DB_RAW   = SYS_CLK / 1000000 * DEBOUNCE_US;
    localparam int DB_CNT   = (DB_RAW < 2) ? 2 : DB_RAW;
    localparam int LONG_RAW = SYS_CLK / 1000 * LONG_MS;
    localparam int LONG_CNT = (LONG_RAW < 1) ? 1 : LONG_RAW;
    localparam int DB_W     = $clog2(DB_CNT + 1);
    localparam int LONG_W   = $clog2(LONG_CNT + 1);

    localparam logic              PIN_IDLE  = (ACTIVE_LOW != 0);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CNT - 1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CNT);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CNT - 1);

    logic              w_sync;
    logic              w_s;
    logic              r_pressed;
    logic              r_press;
    logic              r_release;
    logic              r_long;
    logic [DB_W-1:0]   r_db_cnt;
    logic [LONG_W-1:0] r_long_cnt;

    sync_2ff #(
        .RESET_VAL (PIN_IDLE)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (w_sync)
    );

    // Normalized so that 1 always means "pressed".
    assign w_s = w_sync ^ PIN_IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pressed  <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_long     <= 1'b0;
            r_db_cnt   <= '0;
            r_long_cnt <= '0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            if (clk_en) begin
                if (w_s == r_pressed) begin
                    r_db_cnt <= '0;
                end else if (r_db_cnt == DB_LAST) begin
                    r_pressed <= w_s;
                    r_db_cnt  <= '0;
                    r_press   <= w_s;
                    r_release <= ~w_s;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end

                // Saturating hold counter; the pulse marks the step onto LONG_MAX.
                if (r_pressed) begin
                    if (r_long_cnt != LONG_MAX) begin
                        r_long_cnt <= r_long_cnt + 1'b1;
                        r_long     <= (r_long_cnt == LONG_LAST);
                    end
                end else begin
                    r_long_cnt <= '0;
                end
            end
        end
    end

    assign pressed       = r_pressed;
    assign press         = r_press;
    assign release_pulse = r_release;
    assign long_press    = r_long;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debounce
// Purpose  : Self-checking bench with directed scenarios and random pin traffic.
// Revision : 1.0
// ============================================================================
module tb_button_debounce;

    localparam int DB_CNT   = 8;
    localparam int LONG_CNT = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b1;
    logic btn_in = 1'b1;
    logic pressed, press, release_pulse, long_press;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_press = 0, n_rel = 0, n_long = 0;
    int last_press_cyc = 0, last_long_cyc = 0;

    // Reference model: pin delay line plus a run of consecutive disagreeing samples.
    bit m_meta = 1, m_sync = 1, m_pressed = 0, m_press = 0, m_rel = 0, m_long = 0;
    int hold = 0;
    bit disagree[$];

    button_debounce #(
        .SYS_CLK     (1000000),
        .DEBOUNCE_US (8),
        .LONG_MS     (1),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .clk_en        (clk_en),
        .btn_in        (btn_in),
        .pressed       (pressed),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_tick();
        bit s;
        bit old_p;
        m_press = 0; m_rel = 0; m_long = 0;
        if (!rst_n) begin
            m_meta = 1; m_sync = 1; m_pressed = 0; hold = 0;
            disagree.delete();
        end else begin
            s = ~m_sync;
            m_sync = m_meta;
            m_meta = btn_in;
            if (clk_en) begin
                old_p = m_pressed;
                if (old_p) begin
                    if (hold < LONG_CNT) begin
                        hold++;
                        if (hold == LONG_CNT) m_long = 1;
                    end
                end else begin
                    hold = 0;
                end
                if (s == old_p) begin
                    disagree.delete();
                end else begin
                    disagree.push_back(s);
                    if (disagree.size() == DB_CNT) begin
                        m_pressed = s;
                        m_press = s;
                        m_rel = ~s;
                        disagree.delete();
                    end
                end
            end
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
        cyc++;
        check("pressed", int'(pressed), int'(m_pressed));
        check("press", int'(press), int'(m_press));
        check("release", int'(release_pulse), int'(m_rel));
        check("long_press", int'(long_press), int'(m_long));
        if (press === 1'b1) begin n_press++; last_press_cyc = cyc; end
        if (release_pulse === 1'b1) n_rel++;
        if (long_press === 1'b1) begin n_long++; last_long_cyc = cyc; end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Steps until the selected pulse (0=press, 1=release) appears or budget runs out.
    task automatic wait_evt(input int which, input int maxc, output int cycles);
        int p0, r0;
        p0 = n_press; r0 = n_rel;
        cycles = 0;
        forever begin
            step();
            cycles++;
            if (which == 0 && n_press != p0) break;
            if (which == 1 && n_rel != r0) break;
            if (cycles >= maxc) begin
                check("wait_timeout", cycles, -1);
                break;
            end
        end
    endtask

    initial begin
        int c;
        int base;
        int first_long;
        int runlen;

        // 1: reset with pin idle, then quiet.
        rst_n = 0; btn_in = 1; clk_en = 1;
        run(5);
        check("reset_pressed", int'(pressed), 0);
        rst_n = 1;
        base = n_press + n_rel + n_long;
        run(50);
        check("quiet_after_reset", n_press + n_rel + n_long - base, 0);

        // 2: clean press and release.
        btn_in = 0;
        wait_evt(0, 30, c);
        check("press_latency", c, 10);
        run(5);
        check("pressed_held", int'(pressed), 1);
        btn_in = 1;
        wait_evt(1, 30, c);
        check("release_latency", c, 10);
        check("pressed_after_release", int'(pressed), 0);
        run(5);

        // 3: bounce, then a settled low.
        base = n_press + n_rel;
        for (int i = 0; i < 10; i++) begin
            btn_in = (i % 2 == 0) ? 1'b0 : 1'b1;
            run(3);
        end
        check("no_pulse_in_bounce", n_press + n_rel - base, 0);
        btn_in = 0;
        wait_evt(0, 30, c);
        check("bounce_press_latency", c, 10);
        btn_in = 1;
        wait_evt(1, 30, c);
        run(5);

        // 4: long hold.
        base = n_long;
        btn_in = 0;
        wait_evt(0, 30, c);
        first_long = -1;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (first_long < 0 && n_long != base) first_long = last_long_cyc - last_press_cyc;
        end
        check("long_press_delay", first_long, LONG_CNT);
        check("long_press_once", n_long - base, 1);
        btn_in = 1;
        wait_evt(1, 30, c);
        run(20);
        check("no_long_after_release", n_long - base, 1);

        // 5: clock enable alternating.
        btn_in = 0;
        c = 0;
        for (int i = 0; i < 40 && n_press == last_press_cyc * 0 + n_press; i++) begin
            int p0;
            p0 = n_press;
            clk_en = (i % 2 == 0);
            step();
            c++;
            if (!clk_en) check("pulse_on_disabled", int'(press | release_pulse | long_press), 0);
            if (n_press != p0) break;
        end
        check("gated_press_latency", c, 17);
        clk_en = 1;
        btn_in = 1;
        wait_evt(1, 30, c);
        run(5);

        // 6: reset mid-debounce with pin held.
        btn_in = 0;
        run(7);
        base = n_rel;
        rst_n = 0;
        run(2);
        check("mid_reset_pressed", int'(pressed), 0);
        check("mid_reset_no_release", n_rel - base, 0);
        rst_n = 1;
        wait_evt(0, 30, c);
        check("press_after_reset", c, 10);
        btn_in = 1;
        wait_evt(1, 30, c);

        // 7: random pin, enable and occasional reset traffic.
        for (int k = 0; k < 300; k++) begin
            btn_in = $urandom_range(0, 1);
            runlen = ($urandom_range(0, 19) == 0) ? $urandom_range(1000, 1100)
                                                  : $urandom_range(1, 14);
            for (int j = 0; j < runlen; j++) begin
                clk_en = ($urandom_range(0, 3) != 0);
                rst_n  = ($urandom_range(0, 199) != 0);
                step();
            end
        end
        rst_n = 1; clk_en = 1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
